text_write_engine: RTL and testbench

//  Sits between i2c_slave and video_memory write port. Buffers character writes decoded from I2C
//  in a small FIFO and replays them, one per cycle, into video memory only when its write port is

---
 rtl/text_write_engine_pkg.sv | 22 ++
 rtl/text_write_engine_write_fifo.sv | 51 +++++
 rtl/text_write_engine.sv | 180 ++++++++++++++++++
 tb/tb_text_write_engine.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_write_engine_pkg.sv
// Shared types and default geometry for the text write engine and its FIFO.
package text_write_engine_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StFill  = 2'd2
  } state_e;

  localparam int unsigned DefCols  = 100;
  localparam int unsigned DefRows  = 30;
  localparam int unsigned DefXw    = 7;
  localparam int unsigned DefYw    = 5;
  localparam int unsigned DefAw    = 24;
  localparam int unsigned DefDepth = 8;

  // Pointer width carries one extra wrap bit to tell full from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/text_write_engine_write_fifo.sv
// Small power-of-two FIFO holding queued character writes; head is read combinationally.
module text_write_engine_write_fifo
  import text_write_engine_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned DW    = DefXw + DefYw + DefAw
) (
  input  logic                  clk,
  input  logic                  reset_button,
  input  logic                  i_push,
  input  logic [DW-1:0]         i_data,
  input  logic                  i_pop,
  output logic [DW-1:0]         o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_we;
  logic          w_re;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[IW] != r_rptr[IW]) && (r_wptr[IW-1:0] == r_rptr[IW-1:0]);
  assign o_count = r_wptr - r_rptr;
  assign o_data  = r_mem[r_rptr[IW-1:0]];

  assign w_re = i_pop && !o_empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign w_we = i_push && (!o_full || w_re);

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_we) r_wptr <= r_wptr + 1'b1;
      if (w_re) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wptr[IW-1:0]] <= i_data;
  end

endmodule

// File: rtl/text_write_engine.sv
// Queues I2C character writes and a screen-fill command, replaying them into video memory
// one per cycle whenever its write port is free.
module text_write_engine
  import text_write_engine_pkg::*;
#(
  parameter int unsigned COLS  = DefCols,
  parameter int unsigned ROWS  = DefRows,
  parameter int unsigned XW    = DefXw,
  parameter int unsigned YW    = DefYw,
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic          clk,
  input  logic          reset_button,
  input  logic          req_valid,
  input  logic [XW-1:0] req_x,
  input  logic [YW-1:0] req_y,
  input  logic [AW-1:0] req_attr,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_attr,
  input  logic          mem_ready,
  input  logic          clear_ovf,
  output logic          write,
  output logic [XW-1:0] xtextwrite,
  output logic [YW-1:0] ytextwrite,
  output logic [AW-1:0] value,
  output logic          busy,
  output logic          overflow
);

  localparam int unsigned DW = XW + YW + AW;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [XW-1:0] LastX = XW'(COLS - 1);
  localparam logic [YW-1:0] LastY = YW'(ROWS - 1);

  state_e        r_state;
  state_e        w_state_d;

  logic [XW-1:0] r_fx;
  logic [YW-1:0] r_fy;
  logic [AW-1:0] r_fattr;

  logic          r_write;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_value;
  logic          r_busy;
  logic          r_ovf;

  logic [DW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_d;
  logic          w_in_range;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_fill_wr;
  logic          w_fill_last;
  logic          w_wr;
  logic [XW-1:0] w_wr_x;
  logic [YW-1:0] w_wr_y;
  logic [AW-1:0] w_wr_v;
  logic          w_busy_d;

  text_write_engine_write_fifo #(
    .DEPTH(DEPTH),
    .DW   (DW)
  ) u_fifo (
    .clk         (clk),
    .reset_button(reset_button),
    .i_push      (w_push),
    .i_data      ({req_x, req_y, req_attr}),
    .i_pop       (w_pop),
    .o_data      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign w_in_range = (32'(req_x) < COLS) && (32'(req_y) < ROWS);
  // fill_start pre-empts both draining and filling for the cycle it arrives.
  assign w_pop      = (r_state == StDrain) && !fill_start && mem_ready && !w_empty;
  assign w_push     = req_valid && w_in_range && (!w_full || w_pop);
  assign w_drop     = req_valid && !w_push;
  assign w_count_d  = w_count + CW'(w_push) - CW'(w_pop);

  assign w_fill_wr   = (r_state == StFill) && !fill_start && mem_ready;
  assign w_fill_last = w_fill_wr && (r_fx == LastX) && (r_fy == LastY);

  // State register.
  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) r_state <= StIdle;
    else               r_state <= w_state_d;
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (fill_start)    w_state_d = StFill;
        else if (!w_empty) w_state_d = StDrain;
      end
      StDrain: begin
        if (fill_start)             w_state_d = StFill;
        else if (w_count_d == '0)   w_state_d = StIdle;
      end
      StFill: begin
        if (fill_start)       w_state_d = StFill;
        else if (w_fill_last) w_state_d = (w_count_d != '0) ? StDrain : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output decode: which write, if any, goes to memory on the next edge.
  always_comb begin
    w_wr   = w_pop || w_fill_wr;
    w_wr_x = r_fx;
    w_wr_y = r_fy;
    w_wr_v = r_fattr;
    if (w_pop) begin
      w_wr_x = w_head[DW-1 -: XW];
      w_wr_y = w_head[AW +: YW];
      w_wr_v = w_head[AW-1:0];
    end
    w_busy_d = (w_state_d != StIdle) || (w_count_d != '0);
  end

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      r_fx    <= '0;
      r_fy    <= '0;
      r_fattr <= '0;
    end else if (fill_start) begin
      r_fx    <= '0;
      r_fy    <= '0;
      r_fattr <= fill_attr;
    end else if (w_fill_wr) begin
      if (r_fx == LastX) begin
        r_fx <= '0;
        r_fy <= r_fy + 1'b1;
      end else begin
        r_fx <= r_fx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      r_write <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_value <= '0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_write <= w_wr;
      if (w_wr) begin
        r_x     <= w_wr_x;
        r_y     <= w_wr_y;
        r_value <= w_wr_v;
      end
      r_busy <= w_busy_d;
      // A drop in the same cycle as clear_ovf keeps the flag set.
      if (w_drop)         r_ovf <= 1'b1;
      else if (clear_ovf) r_ovf <= 1'b0;
    end
  end

  assign write      = r_write;
  assign xtextwrite = r_x;
  assign ytextwrite = r_y;
  assign value      = r_value;
  assign busy       = r_busy;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_text_write_engine.sv
// Scoreboard bench: expected writes queued at stimulus time, compared by a negedge monitor.
module tb_text_write_engine;

  localparam int COLS  = 100;
  localparam int ROWS  = 30;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic        f;
    logic [6:0]  x;
    logic [4:0]  y;
    logic [23:0] a;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_button;
  logic        req_valid;
  logic [6:0]  req_x;
  logic [4:0]  req_y;
  logic [23:0] req_attr;
  logic        fill_start;
  logic [23:0] fill_attr;
  logic        mem_ready;
  logic        clear_ovf;
  logic        write;
  logic [6:0]  xtextwrite;
  logic [4:0]  ytextwrite;
  logic [23:0] value;
  logic        busy;
  logic        overflow;

  wr_t         sb_q[$];
  int          wr_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          n_req_q = 0;
  int          n_wr = 0;
  int          cyc = 0;
  logic        ovf_exp = 1'b0;
  wr_t         last_wr = '0;
  logic [23:0] screen [COLS*ROWS];

  text_write_engine dut (
    .clk         (clk),
    .reset_button(reset_button),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_attr    (req_attr),
    .fill_start  (fill_start),
    .fill_attr   (fill_attr),
    .mem_ready   (mem_ready),
    .clear_ovf   (clear_ovf),
    .write       (write),
    .xtextwrite  (xtextwrite),
    .ytextwrite  (ytextwrite),
    .value       (value),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    cyc++;
    if (!reset_button) begin
      last_wr = '0;
    end else if (write) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got x=%0d y=%0d value=%0h required no write",
                 xtextwrite, ytextwrite, value);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        if (!e.f) n_req_q--;
        chk("wr_x", 32'(xtextwrite), 32'(e.x));
        chk("wr_y", 32'(ytextwrite), 32'(e.y));
        chk("wr_value", 32'(value), 32'(e.a));
      end
      if (int'(xtextwrite) < COLS && int'(ytextwrite) < ROWS)
        screen[int'(xtextwrite) + int'(ytextwrite) * COLS] = value;
      n_wr++;
      wr_cyc.push_back(cyc);
      last_wr.x = xtextwrite;
      last_wr.y = ytextwrite;
      last_wr.a = value;
    end else begin
      chk("hold_xy", 32'({xtextwrite, ytextwrite}), 32'({last_wr.x, last_wr.y}));
      chk("hold_value", 32'(value), 32'(last_wr.a));
    end
  end

  // One clock of stimulus; returns 1 ns after the edge with pulses dropped.
  task automatic cyc1(input bit rv, input int x, input int y, input logic [23:0] a,
                      input bit fs, input logic [23:0] fa, input bit mr, input bit co,
                      input bit force_acc);
    bit   inr;
    bit   acc;
    logic ovf_nx;
    wr_t  e;
    req_valid  = rv;
    req_x      = x[6:0];
    req_y      = y[4:0];
    req_attr   = a;
    fill_start = fs;
    fill_attr  = fa;
    mem_ready  = mr;
    clear_ovf  = co;
    inr = (x < COLS) && (y < ROWS);
    acc = rv && inr && (n_req_q < DEPTH || force_acc);
    if (fs) begin
      for (int yy = 0; yy < ROWS; yy++) begin
        for (int xx = 0; xx < COLS; xx++) begin
          e.f = 1'b1; e.x = xx[6:0]; e.y = yy[4:0]; e.a = fa;
          sb_q.push_back(e);
        end
      end
    end
    if (acc) begin
      e.f = 1'b0; e.x = x[6:0]; e.y = y[4:0]; e.a = a;
      sb_q.push_back(e);
      n_req_q++;
    end
    ovf_nx = ovf_exp;
    if (rv && !acc) ovf_nx = 1'b1;
    else if (co)    ovf_nx = 1'b0;
    @(posedge clk);
    #1;
    ovf_exp = ovf_nx;
    chk("overflow", 32'(overflow), 32'(ovf_exp));
    req_valid  = 1'b0;
    fill_start = 1'b0;
    clear_ovf  = 1'b0;
  endtask

  task automatic idle(input int n, input bit mr);
    for (int i = 0; i < n; i++) cyc1(0, 0, 0, 24'h0, 0, 24'h0, mr, 0, 0);
  endtask

  task automatic req(input int x, input int y, input logic [23:0] a, input bit mr);
    cyc1(1, x, y, a, 0, 24'h0, mr, 0, 0);
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (sb_q.size() != 0 && k < bound) begin
      cyc1(0, 0, 0, 24'h0, 0, 24'h0, 1, 0, 0);
      k++;
    end
    chk("drain_done", 32'(sb_q.size()), 32'd0);
    idle(1, 1);
    chk("busy_after_drain", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n0;
    int nbad;
    int k;
    reset_button = 1'b0;
    req_valid = 0; req_x = 0; req_y = 0; req_attr = 0;
    fill_start = 0; fill_attr = 0; mem_ready = 0; clear_ovf = 0;
    #1;
    chk("rst_write", 32'(write), 0);
    chk("rst_xy", 32'({xtextwrite, ytextwrite}), 0);
    chk("rst_value", 32'(value), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    @(posedge clk); @(posedge clk); #1;
    reset_button = 1'b1;

    // Single write and its two-edge latency.
    req(5, 3, 24'hA5A5A5, 1);
    chk("lat_n", 32'(write), 0);
    chk("busy_queued", 32'(busy), 1);
    idle(1, 1);
    chk("lat_n1", 32'(write), 0);
    idle(1, 1);
    chk("lat_n2", 32'(write), 1);
    drain(20);

    // Stall then release: writes in order on consecutive cycles.
    base = wr_cyc.size();
    req(10, 4, 24'h000101, 0);
    req(11, 4, 24'h000202, 0);
    req(12, 4, 24'h000303, 0);
    idle(10, 0);
    drain(20);
    chk("stall_count", 32'(wr_cyc.size() - base), 3);
    if (wr_cyc.size() - base == 3) begin
      chk("stall_consec1", 32'(wr_cyc[base+1] - wr_cyc[base]), 1);
      chk("stall_consec2", 32'(wr_cyc[base+2] - wr_cyc[base+1]), 1);
    end

    // Overflow: nine back-to-back, eight kept.
    for (int i = 0; i < 9; i++) req(i, 7, 24'h100 + 24'(i), 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("busy_full", 32'(busy), 1);
    cyc1(1, 20, 7, 24'hBAD, 0, 24'h0, 0, 1, 0);
    cyc1(0, 0, 0, 24'h0, 0, 24'h0, 0, 1, 0);
    chk("ovf_cleared", 32'(overflow), 0);
    // Full FIFO accepts a push when the head pops in the same cycle.
    cyc1(1, 21, 7, 24'h0ABCDE, 0, 24'h0, 1, 0, 1);
    drain(40);

    // Out of range, plus the last legal cell.
    req(100, 0, 24'h111111, 1);
    req(0, 30, 24'h222222, 1);
    chk("oor_ovf", 32'(overflow), 1);
    idle(4, 1);
    req(99, 29, 24'h333333, 1);
    drain(20);
    cyc1(0, 0, 0, 24'h0, 0, 24'h0, 1, 1, 0);

    // Randomised traffic with stalls, clears and out-of-range requests.
    for (int i = 0; i < 400; i++) begin
      bit rv;
      bit mr;
      bit co;
      int x;
      int y;
      rv = ($urandom_range(0, 1) == 1);
      mr = ($urandom_range(0, 9) < 7);
      co = ($urandom_range(0, 9) == 0);
      x = $urandom_range(0, COLS - 1);
      y = $urandom_range(0, ROWS - 1);
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 1) x = $urandom_range(100, 127);
        else y = $urandom_range(30, 31);
      end else if (n_req_q >= DEPTH) begin
        rv = 0;
      end
      cyc1(rv, x, y, 24'($urandom), 0, 24'h0, mr, co, 0);
    end
    drain(60);
    cyc1(0, 0, 0, 24'h0, 0, 24'h0, 1, 1, 0);

    // Full-screen fill covers every cell exactly once.
    for (int i = 0; i < COLS * ROWS; i++) screen[i] = 24'hFFFFFF;
    n0 = n_wr;
    cyc1(0, 0, 0, 24'h0, 1, 24'h000020, 1, 0, 0);
    chk("busy_fill", 32'(busy), 1);
    drain(3100);
    chk("fill_writes", 32'(n_wr - n0), 32'(COLS * ROWS));
    nbad = 0;
    for (int i = 0; i < COLS * ROWS; i++) if (screen[i] !== 24'h000020) nbad++;
    chk("fill_cover", 32'(nbad), 0);

    // Request during fill lands after the fill.
    cyc1(0, 0, 0, 24'h0, 1, 24'h00002E, 1, 0, 0);
    idle(5, 1);
    req(1, 1, 24'h000041, 1);
    drain(3100);
    chk("fillq_cell11", 32'(screen[1 + COLS]), 32'h41);
    chk("fillq_cell00", 32'(screen[0]), 32'h2E);

    // Reset in the middle of a fill.
    n0 = n_wr;
    cyc1(0, 0, 0, 24'h0, 1, 24'h000055, 1, 0, 0);
    k = 0;
    while (n_wr - n0 < 500 && k < 700) begin
      idle(1, 1);
      k++;
    end
    chk("fill_reached_500", 32'(n_wr - n0 >= 500), 1);
    #2;
    reset_button = 1'b0;
    #1;
    chk("mid_rst_write", 32'(write), 0);
    chk("mid_rst_xy", 32'({xtextwrite, ytextwrite}), 0);
    chk("mid_rst_value", 32'(value), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    sb_q.delete();
    n_req_q = 0;
    ovf_exp = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset_button = 1'b1;
    idle(20, 1);
    chk("post_rst_busy", 32'(busy), 0);
    req(7, 2, 24'h123456, 1);
    drain(20);

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
